// File: rtl/m68k_bus_pkg.sv
// Shared types and constants for the 68000-style asynchronous bus master.
// Used by m68k_bus_master and m68k_sync2.
package m68k_bus_pkg;

  localparam int unsigned ADDR_W             = 20;
  localparam int unsigned DATA_W             = 8;
  localparam int unsigned FC_W               = 3;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 255;

  // Function code of an interrupt-acknowledge cycle, normally answered by _vpa.
  localparam logic [FC_W-1:0] FC_INTACK = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    STRB,
    WDS,
    WAIT,
    TERM,
    RECOV
  } state_e;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [FC_W-1:0]   fc;
  } bus_req_t;

endpackage

// File: rtl/m68k_sync2.sv
// Two-flop synchronizer for an asynchronous active-low bus input.
// Resets to 1 so a strobe-style input reads as deasserted out of reset.
module m68k_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/m68k_bus_master.sv
// 68000-style asynchronous bus master: one byte read or write per request.
// Define BUS_TIMEOUT_EN to add a WAIT-state timeout and _berr termination.
module m68k_bus_master
  import m68k_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              _reset,
  input  logic              req,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [FC_W-1:0]   req_fc,
  output logic              busy,
  output logic              ack,
  output logic              err,
  output logic              avec,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] addr,
  output logic [FC_W-1:0]   fc,
  output logic              rw,
  output logic              _as,
  output logic              _ds,
  output logic [DATA_W-1:0] da_out,
  output logic              da_oe,
  input  logic [DATA_W-1:0] da_in,
  input  logic              _dtack,
  input  logic              _vpa,
  input  logic              _berr
);

  // A zero timeout would fault every cycle before any slave could answer.
  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("m68k_bus_master: TIMEOUT_CYCLES must be nonzero");
  end

  logic s_dtack, s_vpa, s_berr;

  m68k_sync2 u_sync_dtack (.clk(clk), .rst_n(_reset), .d(_dtack), .q(s_dtack));
  m68k_sync2 u_sync_vpa   (.clk(clk), .rst_n(_reset), .d(_vpa),   .q(s_vpa));
  m68k_sync2 u_sync_berr  (.clk(clk), .rst_n(_reset), .d(_berr),  .q(s_berr));

  state_e   state, state_next;
  bus_req_t lat, lat_next;

  logic term_fault, term_avec, term_data;
  logic busy_d, ack_d, err_d, avec_d, rw_d, as_d, ds_d, da_oe_d;
  logic [DATA_W-1:0] rdata_d;

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_hit;

  // Counts WAIT cycles; cleared whenever the FSM is elsewhere.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      wait_cnt <= '0;
    end else if (state != WAIT) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_berr;
  assign unused_berr = s_berr;
`endif

  // Next state, request latch and termination cause.
  always_comb begin
    state_next = state;
    lat_next   = lat;
    term_fault = 1'b0;
    term_avec  = 1'b0;
    term_data  = 1'b0;

    unique case (state)
      IDLE: begin
        if (req) begin
          lat_next   = '{rw: req_rw, addr: req_addr, wdata: req_wdata, fc: req_fc};
          state_next = ADDR;
        end
      end
      ADDR:  state_next = STRB;
      STRB:  state_next = lat.rw ? WAIT : WDS;
      WDS:   state_next = WAIT;
      WAIT: begin
        if (!s_dtack) begin
          state_next = TERM;
          term_data  = lat.rw;
        end else if (!s_vpa) begin
          state_next = TERM;
          term_avec  = 1'b1;
        end
`ifdef BUS_TIMEOUT_EN
        else if (timeout_hit) begin
          state_next = TERM;
          term_fault = 1'b1;
        end
        // Bus error overrides any simultaneous _dtack or _vpa.
        if (!s_berr) begin
          state_next = TERM;
          term_fault = 1'b1;
          term_avec  = 1'b0;
          term_data  = 1'b0;
        end
`endif
      end
      TERM:    state_next = RECOV;
      RECOV:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output values for the coming cycle, decoded from the next state.
  always_comb begin
    busy_d  = (state_next != IDLE);
    ack_d   = (state_next == TERM);
    err_d   = ack_d & term_fault;
    avec_d  = ack_d & term_avec;
    as_d    = !(state_next inside {STRB, WDS, WAIT});
    ds_d    = !((state_next inside {WDS, WAIT}) || (state_next == STRB && lat_next.rw));
    rw_d    = (state_next == IDLE) ? 1'b1 : lat_next.rw;
    da_oe_d = !lat_next.rw && (state_next inside {ADDR, STRB, WDS, WAIT, TERM});
    rdata_d = rdata;
    if (ack_d && term_data) begin
      rdata_d = da_in;
    end else if (ack_d && term_avec && lat.rw) begin
      rdata_d = '1;
    end
  end

  // State and registered outputs; async reset releases strobes at once.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state  <= IDLE;
      lat    <= '0;
      busy   <= 1'b0;
      ack    <= 1'b0;
      err    <= 1'b0;
      avec   <= 1'b0;
      rdata  <= '0;
      addr   <= '0;
      fc     <= '0;
      rw     <= 1'b1;
      _as    <= 1'b1;
      _ds    <= 1'b1;
      da_out <= '0;
      da_oe  <= 1'b0;
    end else begin
      state  <= state_next;
      lat    <= lat_next;
      busy   <= busy_d;
      ack    <= ack_d;
      err    <= err_d;
      avec   <= avec_d;
      rdata  <= rdata_d;
      addr   <= lat_next.addr;
      fc     <= lat_next.fc;
      rw     <= rw_d;
      _as    <= as_d;
      _ds    <= ds_d;
      da_out <= lat_next.wdata;
      da_oe  <= da_oe_d;
    end
  end

endmodule

// File: tb/tb_m68k_bus_master.sv
// Self-checking bench for m68k_bus_master; random bus cycles are checked
// against a transaction-level model. Honours BUS_TIMEOUT_EN like the RTL.
module tb_m68k_bus_master;
  import m68k_bus_pkg::*;

  localparam int unsigned TB_TIMEOUT = 8;
`ifdef BUS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // Termination kinds driven by the bench slave.
  localparam int K_DTACK = 0;
  localparam int K_VPA   = 1;
  localparam int K_BOTH  = 2;
  localparam int K_BERR  = 3;
  localparam int K_NONE  = 4;

  logic        clk, rst_n;
  logic        req, req_rw;
  logic [19:0] req_addr;
  logic [7:0]  req_wdata;
  logic [2:0]  req_fc;
  logic        busy, ack, err, avec;
  logic [7:0]  rdata;
  logic [19:0] addr;
  logic [2:0]  fc;
  logic        rw, as_n, ds_n;
  logic [7:0]  da_out;
  logic        da_oe;
  logic [7:0]  da_in;
  logic        dtack_n, vpa_n, berr_n;

  int n_pass = 0;
  int n_total = 0;
  logic [7:0] model_rdata = 8'h00;

  typedef struct {
    int         as_fall;
    int         ds_fall;
    int         ack_cnt;
    int         ack_at;
    logic       err;
    logic       avec;
    logic [7:0] rdata;
    logic       bus_ok;
    logic       oe_ok;
    logic       oe_recov;
    logic       busy_recov;
    logic       strobes_at_ack;
    logic       idle_after;
    logic       timed_out;
  } obs_t;

  m68k_bus_master #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk(clk), ._reset(rst_n), .req(req), .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_fc(req_fc), .busy(busy), .ack(ack), .err(err),
    .avec(avec), .rdata(rdata), .addr(addr), .fc(fc), .rw(rw), ._as(as_n),
    ._ds(ds_n), .da_out(da_out), .da_oe(da_oe), .da_in(da_in), ._dtack(dtack_n),
    ._vpa(vpa_n), ._berr(berr_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one bus cycle as requester and slave, recording what was observed.
  task automatic run_txn(input logic t_rw, input logic [19:0] t_addr, input logic [7:0] t_wdata,
                         input logic [2:0] t_fc, input int kind, input int dly,
                         input logic [7:0] t_din, input bit junk, input int bound, output obs_t o);
    int  cyc;
    bit  done;
    o = '{as_fall: -1, ds_fall: -1, ack_cnt: 0, ack_at: -1, err: 1'bx, avec: 1'bx, rdata: 8'hxx,
          bus_ok: 1'b1, oe_ok: 1'b1, oe_recov: 1'bx, busy_recov: 1'bx, strobes_at_ack: 1'bx,
          idle_after: 1'b1, timed_out: 1'b0};
    @(negedge clk);
    req = 1'b1; req_rw = t_rw; req_addr = t_addr; req_wdata = t_wdata; req_fc = t_fc;
    da_in = t_din; dtack_n = 1'b1; vpa_n = 1'b1; berr_n = 1'b1;
    cyc = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) req = 1'b0;
      if (as_n === 1'b0 && o.as_fall < 0) o.as_fall = cyc;
      if (ds_n === 1'b0 && o.ds_fall < 0) o.ds_fall = cyc;
      if (as_n === 1'b0) begin
        if (addr !== t_addr || fc !== t_fc || rw !== t_rw) o.bus_ok = 1'b0;
        if (t_rw ? (da_oe !== 1'b0) : (da_oe !== 1'b1 || da_out !== t_wdata)) o.oe_ok = 1'b0;
      end
      if (ack === 1'b1) begin
        o.ack_cnt++;
        if (o.ack_at < 0) begin
          o.ack_at = cyc; o.err = err; o.avec = avec; o.rdata = rdata;
          o.strobes_at_ack = as_n & ds_n;
          if (!t_rw && (da_oe !== 1'b1 || da_out !== t_wdata)) o.oe_ok = 1'b0;
        end
        dtack_n = 1'b1; vpa_n = 1'b1; berr_n = 1'b1;
      end
      if (o.ack_at >= 0) begin
        if (cyc == o.ack_at + 1) begin
          o.oe_recov = da_oe;
          o.busy_recov = busy;
        end
        if (cyc >= o.ack_at + 2 && busy !== 1'b0) o.idle_after = 1'b0;
        if (cyc == o.ack_at + 3) done = 1'b1;
      end else if (cyc >= bound) begin
        o.timed_out = 1'b1;
        done = 1'b1;
      end
      if (o.as_fall >= 0 && !done) begin
        if (junk && cyc == o.as_fall + 1) begin
          req = 1'b1; req_rw = 1'($urandom); req_addr = 20'($urandom);
          req_wdata = 8'($urandom); req_fc = 3'($urandom);
        end
        if (cyc == o.as_fall + 2) req = 1'b0;
        if (o.ack_at < 0 && cyc == o.as_fall + dly) begin
          case (kind)
            K_DTACK: dtack_n = 1'b0;
            K_VPA:   vpa_n = 1'b0;
            K_BOTH:  begin dtack_n = 1'b0; vpa_n = 1'b0; end
            K_BERR:  begin berr_n = 1'b0; dtack_n = 1'b0; end
            default: ;
          endcase
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 1'b0; req_rw = 1'b1; req_addr = '0; req_wdata = '0; req_fc = '0;
    da_in = '0; dtack_n = 1'b1; vpa_n = 1'b1; berr_n = 1'b1;
    repeat (3) @(negedge clk);
    n_total++; if (as_n !== 1'b1) $display("FAIL rst_as got=%b exp=1", as_n); else n_pass++;
    n_total++; if (ds_n !== 1'b1) $display("FAIL rst_ds got=%b exp=1", ds_n); else n_pass++;
    n_total++; if (rw !== 1'b1) $display("FAIL rst_rw got=%b exp=1", rw); else n_pass++;
    n_total++; if (da_oe !== 1'b0) $display("FAIL rst_da_oe got=%b exp=0", da_oe); else n_pass++;
    n_total++; if ({ack, err, avec, busy} !== 4'b0)
      $display("FAIL rst_flags got=%b exp=0000", {ack, err, avec, busy}); else n_pass++;
    n_total++; if (addr !== 20'h0 || fc !== 3'h0)
      $display("FAIL rst_addr_fc got=%h/%h exp=0/0", addr, fc); else n_pass++;
    n_total++; if (rdata !== 8'h00) $display("FAIL rst_rdata got=%h exp=00", rdata); else n_pass++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL rst_idle_busy got=%b exp=0", busy); else n_pass++;
  endtask

  task automatic test_read();
    obs_t o;
    run_txn(1'b1, 20'h80010, 8'h00, 3'b101, K_DTACK, 2, 8'h5A, 1'b0, 60, o);
    model_rdata = 8'h5A;
    n_total++; if (o.ack_cnt !== 1) $display("FAIL rd_ack_cnt got=%0d exp=1", o.ack_cnt); else n_pass++;
    n_total++; if (o.rdata !== 8'h5A) $display("FAIL rd_rdata got=%h exp=5a", o.rdata); else n_pass++;
    n_total++; if (o.err !== 1'b0 || o.avec !== 1'b0)
      $display("FAIL rd_err_avec got=%b%b exp=00", o.err, o.avec); else n_pass++;
    n_total++; if (o.as_fall !== 2) $display("FAIL rd_as_fall got=%0d exp=2", o.as_fall); else n_pass++;
    n_total++; if (o.ds_fall !== o.as_fall)
      $display("FAIL rd_ds_with_as got=%0d exp=%0d", o.ds_fall, o.as_fall); else n_pass++;
    n_total++; if (o.ack_at !== o.as_fall + 5)
      $display("FAIL rd_ack_time got=%0d exp=%0d", o.ack_at, o.as_fall + 5); else n_pass++;
    n_total++; if (!o.bus_ok || !o.oe_ok)
      $display("FAIL rd_bus got=%b%b exp=11", o.bus_ok, o.oe_ok); else n_pass++;
    n_total++; if (o.strobes_at_ack !== 1'b1)
      $display("FAIL rd_strobes_term got=%b exp=1", o.strobes_at_ack); else n_pass++;
    n_total++; if (o.busy_recov !== 1'b1 || !o.idle_after)
      $display("FAIL rd_busy_tail got=%b%b exp=11", o.busy_recov, o.idle_after); else n_pass++;
  endtask

  task automatic test_write();
    obs_t o;
    run_txn(1'b0, 20'h7A000, 8'hC3, 3'b001, K_DTACK, 1, 8'h99, 1'b1, 60, o);
    n_total++; if (o.ack_cnt !== 1) $display("FAIL wr_ack_cnt got=%0d exp=1", o.ack_cnt); else n_pass++;
    n_total++; if (o.ds_fall !== o.as_fall + 1)
      $display("FAIL wr_ds_delay got=%0d exp=%0d", o.ds_fall, o.as_fall + 1); else n_pass++;
    n_total++; if (!o.oe_ok) $display("FAIL wr_da_out_oe got=0 exp=1"); else n_pass++;
    n_total++; if (o.oe_recov !== 1'b0) $display("FAIL wr_oe_recov got=%b exp=0", o.oe_recov); else n_pass++;
    n_total++; if (o.rdata !== model_rdata)
      $display("FAIL wr_rdata_hold got=%h exp=%h", o.rdata, model_rdata); else n_pass++;
    n_total++; if (!o.idle_after) $display("FAIL wr_not_queued got=busy exp=idle"); else n_pass++;
  endtask

  task automatic test_vpa();
    obs_t o;
    run_txn(1'b1, 20'hFFFF3, 8'h00, FC_INTACK, K_VPA, 1, 8'h24, 1'b0, 60, o);
    model_rdata = 8'hFF;
    n_total++; if (o.avec !== 1'b1 || o.err !== 1'b0)
      $display("FAIL vpa_avec got=%b%b exp=10", o.avec, o.err); else n_pass++;
    n_total++; if (o.rdata !== 8'hFF) $display("FAIL vpa_rdata got=%h exp=ff", o.rdata); else n_pass++;
    run_txn(1'b1, 20'h00100, 8'h00, 3'b110, K_BOTH, 0, 8'h3C, 1'b0, 60, o);
    model_rdata = 8'h3C;
    n_total++; if (o.avec !== 1'b0) $display("FAIL both_avec got=%b exp=0", o.avec); else n_pass++;
    n_total++; if (o.rdata !== 8'h3C) $display("FAIL both_rdata got=%h exp=3c", o.rdata); else n_pass++;
  endtask

  task automatic test_timeout();
    obs_t o;
    if (TO_EN) begin
      run_txn(1'b1, 20'h12345, 8'h00, 3'b101, K_NONE, 0, 8'hEE, 1'b0, 100, o);
      n_total++; if (o.ack_cnt !== 1 || o.err !== 1'b1)
        $display("FAIL to_rd_err got=%0d/%b exp=1/1", o.ack_cnt, o.err); else n_pass++;
      n_total++; if (o.ack_at !== o.as_fall + 1 + int'(TB_TIMEOUT))
        $display("FAIL to_rd_len got=%0d exp=%0d", o.ack_at, o.as_fall + 1 + int'(TB_TIMEOUT)); else n_pass++;
      n_total++; if (o.rdata !== model_rdata)
        $display("FAIL to_rd_rdata got=%h exp=%h", o.rdata, model_rdata); else n_pass++;
      run_txn(1'b0, 20'h54321, 8'h77, 3'b001, K_NONE, 0, 8'hEE, 1'b0, 100, o);
      n_total++; if (o.err !== 1'b1 || o.ack_at !== o.as_fall + 2 + int'(TB_TIMEOUT))
        $display("FAIL to_wr got=%b/%0d exp=1/%0d", o.err, o.ack_at, o.as_fall + 2 + int'(TB_TIMEOUT)); else n_pass++;
      run_txn(1'b1, 20'h0ABCD, 8'h00, 3'b101, K_BERR, 1, 8'h11, 1'b0, 60, o);
      n_total++; if (o.err !== 1'b1 || o.avec !== 1'b0 || o.rdata !== model_rdata)
        $display("FAIL berr_prio got=%b%b/%h exp=10/%h", o.err, o.avec, o.rdata, model_rdata); else n_pass++;
    end else begin
      run_txn(1'b1, 20'h12345, 8'h00, 3'b101, K_NONE, 0, 8'hEE, 1'b0, 1000, o);
      n_total++; if (!o.timed_out || o.ack_cnt !== 0)
        $display("FAIL nto_no_ack got=%b/%0d exp=1/0", o.timed_out, o.ack_cnt); else n_pass++;
      n_total++; if (busy !== 1'b1 || as_n !== 1'b0)
        $display("FAIL nto_stuck got=%b%b exp=10", busy, as_n); else n_pass++;
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      model_rdata = 8'h00;
      n_total++; if (busy !== 1'b0) $display("FAIL nto_recover got=%b exp=0", busy); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    bit   saw_ack;
    run_txn(1'b1, 20'h22222, 8'h00, 3'b101, K_NONE, 0, 8'h00, 1'b0, 6, o);
    n_total++; if (as_n !== 1'b0 || ds_n !== 1'b0)
      $display("FAIL mid_pre got=%b%b exp=00", as_n, ds_n); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (as_n !== 1'b1 || ds_n !== 1'b1)
      $display("FAIL mid_strobes got=%b%b exp=11", as_n, ds_n); else n_pass++;
    n_total++; if (ack !== 1'b0 || busy !== 1'b0)
      $display("FAIL mid_flags got=%b%b exp=00", ack, busy); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    model_rdata = 8'h00;
    saw_ack = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (ack !== 1'b0) saw_ack = 1'b1;
    end
    n_total++; if (saw_ack) $display("FAIL mid_no_ack got=1 exp=0"); else n_pass++;
    n_total++; if (rdata !== 8'h00) $display("FAIL mid_rdata got=%h exp=00", rdata); else n_pass++;
    run_txn(1'b1, 20'h33333, 8'h00, 3'b101, K_DTACK, 0, 8'hA7, 1'b0, 60, o);
    model_rdata = 8'hA7;
    n_total++; if (o.ack_cnt !== 1 || o.rdata !== 8'hA7 || o.err !== 1'b0)
      $display("FAIL mid_next got=%0d/%h/%b exp=1/a7/0", o.ack_cnt, o.rdata, o.err); else n_pass++;
  endtask

  task automatic test_random();
    obs_t       o;
    logic       t_rw;
    logic [7:0] t_din, exp_rdata;
    int         kind, dly;
    logic       exp_err, exp_avec;
    for (int i = 0; i < 40; i++) begin
      t_rw  = 1'($urandom);
      t_din = 8'($urandom);
      kind  = int'($urandom_range(0, 3));
      dly   = int'($urandom_range(0, 4));
      run_txn(t_rw, 20'($urandom), 8'($urandom), 3'($urandom), kind, dly, t_din,
              1'($urandom), 60, o);
      exp_err  = TO_EN && (kind == K_BERR);
      exp_avec = (kind == K_VPA);
      exp_rdata = model_rdata;
      if (t_rw && !exp_err) exp_rdata = exp_avec ? 8'hFF : t_din;
      model_rdata = exp_rdata;
      n_total++; if (o.ack_cnt !== 1 || o.err !== exp_err || o.avec !== exp_avec)
        $display("FAIL rnd%0d_term got=%0d/%b%b exp=1/%b%b", i, o.ack_cnt, o.err, o.avec,
                 exp_err, exp_avec); else n_pass++;
      n_total++; if (o.rdata !== exp_rdata)
        $display("FAIL rnd%0d_rdata got=%h exp=%h", i, o.rdata, exp_rdata); else n_pass++;
      n_total++; if (o.ds_fall !== o.as_fall + (t_rw ? 0 : 1) || o.ack_at !== o.as_fall + dly + 3)
        $display("FAIL rnd%0d_timing got=%0d/%0d exp=%0d/%0d", i, o.ds_fall, o.ack_at,
                 o.as_fall + (t_rw ? 0 : 1), o.as_fall + dly + 3); else n_pass++;
      n_total++; if (!o.bus_ok || !o.oe_ok || o.oe_recov !== 1'b0 || !o.idle_after)
        $display("FAIL rnd%0d_bus got=%b%b%b%b exp=1101", i, o.bus_ok, o.oe_ok, o.oe_recov,
                 o.idle_after); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_vpa();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
